// File: rtl/mrd_stage_seq_if.sv
// Handshake/bus bundle for the mixed-radix DFT stage sequencer.
// master: transform controller / datapath side (drives config, stall, write-back strobe).
// slave : the sequencer itself (drives stage control, issue strobe and status).
interface mrd_stage_seq_if #(
  parameter int unsigned MAX_STAGES = 6,
  parameter int unsigned wCNT       = 12
) ();
  // Controller -> sequencer
  logic                       start;
  logic                       inverse;
  logic [2:0]                 num_stages;
  logic [3*MAX_STAGES-1:0]    factors;
  logic [wCNT*MAX_STAGES-1:0] bfly_num;
  logic                       rd_stall;
  logic                       wb_val;
  // Sequencer -> datapath / memory / controller
  logic                       stage_sop;
  logic                       stage_inverse;
  logic                       rd_en;
  logic [wCNT-1:0]            rd_idx;
  logic [2:0]                 cur_stage;
  logic [2:0]                 cur_factor;
  logic                       bank_sel;
  logic                       busy;
  logic                       done;
  logic                       err;

  modport master (
    output start, inverse, num_stages, factors, bfly_num, rd_stall, wb_val,
    input  stage_sop, stage_inverse, rd_en, rd_idx, cur_stage, cur_factor, bank_sel, busy,
           done, err
  );

  modport slave (
    input  start, inverse, num_stages, factors, bfly_num, rd_stall, wb_val,
    output stage_sop, stage_inverse, rd_en, rd_idx, cur_stage, cur_factor, bank_sel, busy,
           done, err
  );
endinterface

// File: rtl/mrd_stage_seq.sv
// Stage sequencer for the mixed-radix (2/3/4/5) DFT engine.
// Steps through a latched list of radix factors, one per stage: pulses stage_sop, issues one
// butterfly read per non-stalled cycle, counts datapath write-backs, waits GUARD cycles for the
// exponent/margin capture, then flips the ping-pong bank and moves on.
// Ports:
//   clk    - clock
//   rst_n  - synchronous active-low reset
//   seq_if - slave side of mrd_stage_seq_if (config/stall/write-back in, stage control out)
// All outputs are registered. GUARD must be at least 1.
module mrd_stage_seq #(
  parameter int unsigned MAX_STAGES = 6,
  parameter int unsigned wCNT       = 12,
  parameter int unsigned GUARD      = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  mrd_stage_seq_if.slave seq_if
);

  typedef enum logic [2:0] {
    StIdle, StSop, StIssue, StDrain, StGap, StNext, StFin
  } state_e;

  state_e                     state_q, state_d;
  logic [2:0]                 num_stages_q, num_stages_d;
  logic [3*MAX_STAGES-1:0]    factors_q, factors_d;
  logic [wCNT*MAX_STAGES-1:0] bfly_q, bfly_d;
  logic [wCNT-1:0]            iss_cnt_q, iss_cnt_d;
  logic [wCNT-1:0]            wb_cnt_q, wb_cnt_d;
  logic [wCNT-1:0]            gap_cnt_q, gap_cnt_d;

  logic                       stage_sop_q, stage_sop_d;
  logic                       stage_inverse_q, stage_inverse_d;
  logic                       rd_en_q, rd_en_d;
  logic [wCNT-1:0]            rd_idx_q, rd_idx_d;
  logic [2:0]                 cur_stage_q, cur_stage_d;
  logic [2:0]                 cur_factor_q, cur_factor_d;
  logic                       bank_sel_q, bank_sel_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  logic                       cfg_legal;
  logic [wCNT-1:0]            cur_bfly;
  logic [2:0]                 next_stage;
  logic [2:0]                 next_factor;
  logic                       wb_err;
  logic                       more_stages;

  // Legality of the config presented with start; only stages below num_stages are inspected.
  always_comb begin
    cfg_legal = (seq_if.num_stages != 3'd0) &&
                (int'(seq_if.num_stages) <= int'(MAX_STAGES));
    for (int s = 0; s < int'(MAX_STAGES); s++) begin
      if (s < int'(seq_if.num_stages)) begin
        if ((seq_if.factors[3*s +: 3] < 3'd2) || (seq_if.factors[3*s +: 3] > 3'd5)) begin
          cfg_legal = 1'b0;
        end
        if (seq_if.bfly_num[wCNT*s +: wCNT] == '0) begin
          cfg_legal = 1'b0;
        end
      end
    end
  end

  assign next_stage  = cur_stage_q + 3'd1;
  assign more_stages = ({1'b0, cur_stage_q} + 4'd1) < {1'b0, num_stages_q};

  // Per-stage lookups from the latched config.
  always_comb begin
    cur_bfly    = '0;
    next_factor = '0;
    for (int s = 0; s < int'(MAX_STAGES); s++) begin
      if (cur_stage_q == 3'(s)) begin
        cur_bfly = bfly_q[wCNT*s +: wCNT];
      end
      if (next_stage == 3'(s)) begin
        next_factor = factors_q[3*s +: 3];
      end
    end
  end

  // A write-back is an error when nothing can legitimately be in flight, or when the stage
  // already has all its results; such a pulse is not counted.
  assign wb_err = seq_if.wb_val &&
                  ((state_q == StIdle) || (state_q == StGap) || (state_q == StFin) ||
                   (wb_cnt_q == cur_bfly));

  always_comb begin
    state_d         = state_q;
    num_stages_d    = num_stages_q;
    factors_d       = factors_q;
    bfly_d          = bfly_q;
    iss_cnt_d       = iss_cnt_q;
    wb_cnt_d        = (seq_if.wb_val && !wb_err) ? wb_cnt_q + 1'b1 : wb_cnt_q;
    gap_cnt_d       = gap_cnt_q;
    stage_sop_d     = 1'b0;
    stage_inverse_d = stage_inverse_q;
    rd_en_d         = 1'b0;
    rd_idx_d        = rd_idx_q;
    cur_stage_d     = cur_stage_q;
    cur_factor_d    = cur_factor_q;
    bank_sel_d      = bank_sel_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    err_d           = err_q;

    unique case (state_q)
      StIdle: begin
        if (seq_if.start) begin
          num_stages_d    = seq_if.num_stages;
          factors_d       = seq_if.factors;
          bfly_d          = seq_if.bfly_num;
          stage_inverse_d = seq_if.inverse;
          cur_stage_d     = '0;
          bank_sel_d      = 1'b0;
          rd_idx_d        = '0;
          if (cfg_legal) begin
            state_d      = StSop;
            stage_sop_d  = 1'b1;
            busy_d       = 1'b1;
            err_d        = 1'b0;
            cur_factor_d = seq_if.factors[2:0];
            iss_cnt_d    = '0;
            wb_cnt_d     = '0;
          end else begin
            state_d = StFin;
            err_d   = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      // The issue decision is taken at the edge entering each ISSUE cycle so rd_en is registered.
      StSop, StIssue: begin
        if ((state_q == StIssue) && (iss_cnt_q == cur_bfly)) begin
          state_d = StDrain;
        end else begin
          state_d = StIssue;
          rd_en_d = ~seq_if.rd_stall;
          if (!seq_if.rd_stall) begin
            rd_idx_d  = iss_cnt_q;
            iss_cnt_d = iss_cnt_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (wb_cnt_q == cur_bfly) begin
          state_d   = StGap;
          gap_cnt_d = '0;
        end
      end
      StGap: begin
        if (gap_cnt_q == wCNT'(GUARD - 1)) begin
          state_d = StNext;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      StNext: begin
        if (more_stages) begin
          state_d      = StSop;
          stage_sop_d  = 1'b1;
          cur_stage_d  = next_stage;
          cur_factor_d = next_factor;
          bank_sel_d   = ~bank_sel_q;
          iss_cnt_d    = '0;
          wb_cnt_d     = '0;
        end else begin
          state_d = StFin;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Stray write-backs win over the clear-on-start so they are never lost.
    if (wb_err) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      num_stages_q    <= '0;
      factors_q       <= '0;
      bfly_q          <= '0;
      iss_cnt_q       <= '0;
      wb_cnt_q        <= '0;
      gap_cnt_q       <= '0;
      stage_sop_q     <= 1'b0;
      stage_inverse_q <= 1'b0;
      rd_en_q         <= 1'b0;
      rd_idx_q        <= '0;
      cur_stage_q     <= '0;
      cur_factor_q    <= '0;
      bank_sel_q      <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      num_stages_q    <= num_stages_d;
      factors_q       <= factors_d;
      bfly_q          <= bfly_d;
      iss_cnt_q       <= iss_cnt_d;
      wb_cnt_q        <= wb_cnt_d;
      gap_cnt_q       <= gap_cnt_d;
      stage_sop_q     <= stage_sop_d;
      stage_inverse_q <= stage_inverse_d;
      rd_en_q         <= rd_en_d;
      rd_idx_q        <= rd_idx_d;
      cur_stage_q     <= cur_stage_d;
      cur_factor_q    <= cur_factor_d;
      bank_sel_q      <= bank_sel_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
    end
  end

  assign seq_if.stage_sop     = stage_sop_q;
  assign seq_if.stage_inverse = stage_inverse_q;
  assign seq_if.rd_en         = rd_en_q;
  assign seq_if.rd_idx        = rd_idx_q;
  assign seq_if.cur_stage     = cur_stage_q;
  assign seq_if.cur_factor    = cur_factor_q;
  assign seq_if.bank_sel      = bank_sel_q;
  assign seq_if.busy          = busy_q;
  assign seq_if.done          = done_q;
  assign seq_if.err           = err_q;

endmodule

// File: tb/tb_mrd_stage_seq.sv
// Self-checking bench for mrd_stage_seq: expected sop/issue/done events are queued when a
// transform is started and popped by an independent monitor as the DUT produces them.
module tb_mrd_stage_seq;
  localparam int unsigned MAX_STAGES = 6;
  localparam int unsigned WCNT       = 12;
  localparam int unsigned GUARD      = 3;
  localparam int          DELAY      = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mrd_stage_seq_if #(.MAX_STAGES(MAX_STAGES), .wCNT(WCNT)) seq_if ();

  mrd_stage_seq #(
    .MAX_STAGES(MAX_STAGES),
    .wCNT      (WCNT),
    .GUARD     (GUARD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seq_if(seq_if)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] rd_q[$];
  logic [31:0] sop_q[$];
  logic [31:0] done_q[$];
  int          sop_cnt;
  int          done_cnt;
  int          rd_cnt [MAX_STAGES];
  int          wb_sent;
  logic        inject   = 1'b0;
  logic        stall_en = 1'b0;
  int          cfg_ns;
  int          cfg_f [MAX_STAGES];
  int          cfg_b [MAX_STAGES];
  logic        cfg_inv;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] pk_rd(input int st, input int bank, input int f, input int idx);
    return {13'd0, 3'(st), 1'(bank), 3'(f), 12'(idx)};
  endfunction

  function automatic logic [31:0] pk_sop(input int st, input int bank, input int f,
                                         input logic inv);
    return {23'd0, 3'(st), 1'(bank), 3'(f), inv, 1'b1};
  endfunction

  function automatic logic [31:0] pk_done(input logic e);
    return {30'd0, 1'b0, e};  // busy must already be low
  endfunction

  function automatic logic [31:0] all_outs();
    return {7'd0, seq_if.stage_sop, seq_if.stage_inverse, seq_if.rd_en, seq_if.rd_idx,
            seq_if.cur_stage, seq_if.cur_factor, seq_if.bank_sel, seq_if.busy, seq_if.done,
            seq_if.err};
  endfunction

  task automatic apply_cfg();
    seq_if.num_stages = 3'(cfg_ns);
    seq_if.inverse    = cfg_inv;
    for (int s = 0; s < int'(MAX_STAGES); s++) begin
      seq_if.factors[3*s +: 3]        = 3'(cfg_f[s]);
      seq_if.bfly_num[WCNT*s +: WCNT] = WCNT'(cfg_b[s]);
    end
  endtask

  task automatic clear_stats();
    sop_cnt  = 0;
    done_cnt = 0;
    wb_sent  = 0;
    for (int s = 0; s < int'(MAX_STAGES); s++) rd_cnt[s] = 0;
  endtask

  task automatic push_legal(input logic exp_err);
    for (int s = 0; s < cfg_ns; s++) begin
      sop_q.push_back(pk_sop(s, s % 2, cfg_f[s], cfg_inv));
      for (int i = 0; i < cfg_b[s]; i++) rd_q.push_back(pk_rd(s, s % 2, cfg_f[s], i));
    end
    done_q.push_back(pk_done(exp_err));
  endtask

  // Leaves the bench at t+1 (#1 after the edge that sampled start).
  task automatic do_start();
    @(posedge clk); #1;
    seq_if.start = 1'b1;
    @(posedge clk); #1;
    seq_if.start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input bit fin_start);
    int c = 0;
    while (!seq_if.done && c < limit) begin
      @(posedge clk); #1;
      c++;
    end
    check("done_seen", 32'(seq_if.done), 32'd1);
    check("busy_low_at_done", 32'(seq_if.busy), 32'd0);
    if (seq_if.done && fin_start) begin
      seq_if.start = 1'b1;  // sampled in the FIN cycle: must be ignored
      @(posedge clk); #1;
      seq_if.start = 1'b0;
    end
  endtask

  task automatic check_counts();
    check("sop_count", 32'(sop_cnt), 32'(cfg_ns));
    for (int s = 0; s < cfg_ns; s++) check($sformatf("rd_count_s%0d", s), 32'(rd_cnt[s]),
                                           32'(cfg_b[s]));
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'd1);
  endtask

  // Datapath model: each issued butterfly comes back DELAY cycles later; optional extra pulse.
  initial begin : driver
    logic [DELAY-1:0] dl;
    dl              = '0;
    seq_if.wb_val   = 1'b0;
    seq_if.rd_stall = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        dl            = '0;
        seq_if.wb_val = 1'b0;
      end else begin
        if (dl[DELAY-1]) wb_sent++;
        seq_if.wb_val = dl[DELAY-1] | inject;
        dl            = {dl[DELAY-2:0], seq_if.rd_en};
      end
      seq_if.rd_stall = stall_en && ($urandom_range(99) < 30);
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (seq_if.stage_sop) begin
          sop_cnt++;
          if (sop_q.size() == 0) check("sop_unexpected", 32'(seq_if.stage_sop), 32'd0);
          else check("sop_event", {23'd0, seq_if.cur_stage, seq_if.bank_sel, seq_if.cur_factor,
                                   seq_if.stage_inverse, seq_if.busy}, sop_q.pop_front());
        end
        if (seq_if.rd_en) begin
          if (int'(seq_if.cur_stage) < int'(MAX_STAGES)) rd_cnt[seq_if.cur_stage]++;
          if (rd_q.size() == 0) check("rd_unexpected", 32'(seq_if.rd_en), 32'd0);
          else check("rd_event", {13'd0, seq_if.cur_stage, seq_if.bank_sel, seq_if.cur_factor,
                                  seq_if.rd_idx}, rd_q.pop_front());
        end
        if (seq_if.done) begin
          done_cnt++;
          if (done_q.size() == 0) check("done_unexpected", 32'(seq_if.done), 32'd0);
          else check("done_event", {30'd0, seq_if.busy, seq_if.err}, done_q.pop_front());
        end
      end
    end
  end

  initial begin : stim
    int c;
    seq_if.start      = 1'b0;
    seq_if.inverse    = 1'b0;
    seq_if.num_stages = '0;
    seq_if.factors    = '0;
    seq_if.bfly_num   = '0;
    clear_stats();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_outputs", all_outs(), 32'd0);

    // Legal 5-stage run, no stall
    cfg_ns = 5; cfg_inv = 1'b0;
    cfg_f = '{4, 4, 3, 5, 5, 2};
    cfg_b = '{300, 300, 400, 240, 240, 1};
    apply_cfg(); clear_stats(); push_legal(1'b0);
    do_start();
    check("sop_at_t1", 32'(seq_if.stage_sop), 32'd1);
    check("busy_at_t1", 32'(seq_if.busy), 32'd1);
    @(posedge clk); #1;
    check("first_rd", {31'(seq_if.rd_idx), seq_if.rd_en}, 32'd1);
    wait_done(20000, 1'b0);
    check("err_legal", 32'(seq_if.err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_counts();

    // Back-pressure, inverse direction
    cfg_inv = 1'b1; stall_en = 1'b1;
    apply_cfg(); clear_stats(); push_legal(1'b0);
    do_start();
    wait_done(20000, 1'b0);
    stall_en = 1'b0;
    check("err_stall", 32'(seq_if.err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_counts();

    // Illegal factor in a used stage
    cfg_inv = 1'b0; cfg_f[2] = 6;
    apply_cfg(); clear_stats(); done_q.push_back(pk_done(1'b1));
    do_start();
    check("illegal_done_t1", {30'd0, seq_if.done, seq_if.err}, 32'd3);
    check("illegal_busy", 32'(seq_if.busy), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("illegal_sop_count", 32'(sop_cnt), 32'd0);
    check("illegal_rd_count", 32'(rd_cnt[0] + rd_cnt[1] + rd_cnt[2]), 32'd0);
    check("illegal_done_count", 32'(done_cnt), 32'd1);
    check("err_sticky", 32'(seq_if.err), 32'd1);

    // Legal start clears err; start mid-ISSUE and in FIN are ignored
    cfg_ns = 3; cfg_f = '{2, 3, 5, 2, 2, 2}; cfg_b = '{5, 7, 4, 1, 1, 1};
    apply_cfg(); clear_stats(); push_legal(1'b0);
    do_start();
    check("err_cleared", 32'(seq_if.err), 32'd0);
    @(posedge clk); #1;
    seq_if.num_stages = 3'd1;
    seq_if.factors[2:0] = 3'd4;
    seq_if.start = 1'b1;
    @(posedge clk); #1;
    seq_if.start = 1'b0;
    wait_done(2000, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("busy_after_fin_start", 32'(seq_if.busy), 32'd0);
    check_counts();

    // Reset during stage 2 ISSUE, then a clean restart
    cfg_ns = 5; cfg_f = '{4, 4, 3, 5, 5, 2}; cfg_b = '{300, 300, 400, 240, 240, 1};
    apply_cfg(); clear_stats(); push_legal(1'b0);
    do_start();
    c = 0;
    while (!(seq_if.cur_stage == 3'd2 && seq_if.rd_en) && c < 5000) begin
      @(posedge clk); #1;
      c++;
    end
    check("reached_stage2", 32'(seq_if.cur_stage), 32'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("outputs_after_reset", all_outs(), 32'd0);
    rst_n = 1'b1;
    rd_q.delete(); sop_q.delete(); done_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("no_done_on_reset", 32'(done_cnt), 32'd0);
    check("idle_after_reset", all_outs(), 32'd0);
    cfg_ns = 3; cfg_f = '{2, 3, 5, 2, 2, 2}; cfg_b = '{5, 7, 4, 1, 1, 1};
    apply_cfg(); clear_stats(); push_legal(1'b0);
    do_start();
    wait_done(2000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("restart_err", 32'(seq_if.err), 32'd0);
    check_counts();

    // Excess write-back after stage 0 drains
    cfg_ns = 3; cfg_f = '{5, 3, 4, 2, 2, 2}; cfg_b = '{6, 4, 5, 1, 1, 1};
    apply_cfg(); clear_stats(); push_legal(1'b1);
    do_start();
    c = 0;
    while (wb_sent != cfg_b[0] && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    check("stage0_drained", 32'(wb_sent), 32'(cfg_b[0]));
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    check("excess_err", 32'(seq_if.err), 32'd1);
    check("excess_stage", 32'(seq_if.cur_stage), 32'd0);
    wait_done(2000, 1'b0);
    check("excess_err_at_done", 32'(seq_if.err), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_counts();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
